// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the I/D-side OBI memory arbiter.
//   arb_state_e : arbiter FSM states
//   OWNER_I/D   : encoding of owner_o
//   obi_req_t   : downstream request payload (we, be, addr, wdata)
package obi_arb_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BE_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BURST = 2'd1,
        D_READ  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

endpackage

// File: rtl/obi_mem_arbiter.sv
// Shares one OBI memory port between an I-side burst reader and a D-side
// single-beat read/posted-write requester. One transaction at a time,
// round-robin selection, read responses routed to the owner, watchdog on
// missing responses and detection of unexpected responses.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   i_req_i/i_addr_i         I-side burst read request; i_gnt_o grant
//   i_rvalid_o/i_rdata_o     I-side read beats
//   d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i  D-side request; d_gnt_o grant
//   d_rvalid_o/d_rdata_o     D-side read response
//   m_req_o/m_we_o/m_be_o/m_addr_o/m_wdata_o  downstream request
//   m_gnt_i/m_rvalid_i/m_rdata_i              downstream grant and response
//   owner_o                  last granted side (0 = I, 1 = D)
//   busy_o                   FSM not in IDLE
//   err_o                    one-cycle pulse on timeout or unexpected rvalid
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned BURST_BEATS = 8,
    parameter int unsigned WR_GAP      = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        i_req_i,
    input  logic [63:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic [63:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [7:0]  d_be_i,
    input  logic [63:0] d_addr_i,
    input  logic [63:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [63:0] d_rdata_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [7:0]  m_be_o,
    output logic [63:0] m_addr_o,
    output logic [63:0] m_wdata_o,
    input  logic        m_gnt_i,
    input  logic        m_rvalid_i,
    input  logic [63:0] m_rdata_i,
    output logic        owner_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int unsigned GAP_W  = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
    localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e        state, state_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [WD_W-1:0]   wd_cnt, wd_nxt;
    logic              owner, owner_nxt;
    logic              busy, err;
    logic              err_c;
    logic              sel_d;
    logic              wd_expired;
    logic              m_req_c, i_gnt_c, d_gnt_c, i_rv_c, d_rv_c;
    obi_req_t          sel;

    // Round-robin: on contention the side that was not granted last wins.
    assign sel_d      = d_req_i & (~i_req_i | (owner == OWNER_I));
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

    // Request payload of the selected side; I-side is always a full-word read.
    always_comb begin
        sel = '0;
        if (sel_d) begin
            sel.we    = d_we_i;
            sel.be    = d_be_i;
            sel.addr  = d_addr_i;
            sel.wdata = d_wdata_i;
        end else begin
            sel.we    = 1'b0;
            sel.be    = '1;
            sel.addr  = i_addr_i;
            sel.wdata = '0;
        end
    end

    // Next-state, counters and combinational handshake.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        gap_nxt   = gap_cnt;
        wd_nxt    = wd_cnt;
        owner_nxt = owner;
        err_c     = 1'b0;
        m_req_c   = 1'b0;
        i_gnt_c   = 1'b0;
        d_gnt_c   = 1'b0;
        i_rv_c    = 1'b0;
        d_rv_c    = 1'b0;
        case (state)
            IDLE: begin
                m_req_c = i_req_i | d_req_i;
                i_gnt_c = m_gnt_i & i_req_i & ~sel_d;
                d_gnt_c = m_gnt_i & sel_d;
                err_c   = m_rvalid_i;
                if (m_req_c && m_gnt_i) begin
                    owner_nxt = sel_d ? OWNER_D : OWNER_I;
                    wd_nxt    = '0;
                    if (!sel_d) begin
                        state_nxt = I_BURST;
                        beat_nxt  = '0;
                    end else if (d_we_i) begin
                        state_nxt = D_WRITE;
                        gap_nxt   = GAP_W'(WR_GAP);
                    end else begin
                        state_nxt = D_READ;
                    end
                end
            end
            I_BURST: begin
                i_rv_c = m_rvalid_i;
                if (m_rvalid_i) begin
                    wd_nxt = '0;
                    if (beat_cnt == BEAT_W'(BURST_BEATS - 1)) begin
                        state_nxt = IDLE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat_cnt + BEAT_W'(1);
                    end
                end else if (wd_expired) begin
                    err_c     = 1'b1;
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                    wd_nxt    = '0;
                end else begin
                    wd_nxt = wd_cnt + WD_W'(1);
                end
            end
            D_READ: begin
                d_rv_c = m_rvalid_i;
                if (m_rvalid_i) begin
                    wd_nxt    = '0;
                    state_nxt = IDLE;
                end else if (wd_expired) begin
                    err_c     = 1'b1;
                    state_nxt = IDLE;
                    wd_nxt    = '0;
                end else begin
                    wd_nxt = wd_cnt + WD_W'(1);
                end
            end
            D_WRITE: begin
                err_c = m_rvalid_i;
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            wd_cnt   <= '0;
            owner    <= OWNER_I;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            gap_cnt  <= gap_nxt;
            wd_cnt   <= wd_nxt;
            owner    <= owner_nxt;
            busy     <= (state_nxt != IDLE);
            err      <= err_c;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign m_req_o    = rst_ni & m_req_c;
    assign m_we_o     = rst_ni & sel.we;
    assign m_be_o     = rst_ni ? sel.be    : '0;
    assign m_addr_o   = rst_ni ? sel.addr  : '0;
    assign m_wdata_o  = rst_ni ? sel.wdata : '0;
    assign i_gnt_o    = rst_ni & i_gnt_c;
    assign d_gnt_o    = rst_ni & d_gnt_c;
    assign i_rvalid_o = rst_ni & i_rv_c;
    assign d_rvalid_o = rst_ni & d_rv_c;
    assign i_rdata_o  = rst_ni ? m_rdata_i : '0;
    assign d_rdata_o  = rst_ni ? m_rdata_i : '0;
    assign owner_o    = owner;
    assign busy_o     = busy;
    assign err_o      = err;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: directed scenarios plus a random
// phase, all checked each cycle against a transaction-level model.
module tb_obi_mem_arbiter;

    localparam int unsigned BURST_BEATS = 8;
    localparam int unsigned WR_GAP      = 2;
    localparam int unsigned TIMEOUT     = 64;

    logic        clk_i, rst_ni;
    logic        i_req_i;
    logic [63:0] i_addr_i;
    logic        i_gnt_o, i_rvalid_o;
    logic [63:0] i_rdata_o;
    logic        d_req_i, d_we_i;
    logic [7:0]  d_be_i;
    logic [63:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o;
    logic [63:0] d_rdata_o;
    logic        m_req_o, m_we_o;
    logic [7:0]  m_be_o;
    logic [63:0] m_addr_o, m_wdata_o;
    logic        m_gnt_i, m_rvalid_i;
    logic [63:0] m_rdata_i;
    logic        owner_o, busy_o, err_o;

    int checks   = 0;
    int failures = 0;

    obi_mem_arbiter #(
        .BURST_BEATS(BURST_BEATS),
        .WR_GAP     (WR_GAP),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_req_i   (i_req_i),
        .i_addr_i  (i_addr_i),
        .i_gnt_o   (i_gnt_o),
        .i_rvalid_o(i_rvalid_o),
        .i_rdata_o (i_rdata_o),
        .d_req_i   (d_req_i),
        .d_we_i    (d_we_i),
        .d_be_i    (d_be_i),
        .d_addr_i  (d_addr_i),
        .d_wdata_i (d_wdata_i),
        .d_gnt_o   (d_gnt_o),
        .d_rvalid_o(d_rvalid_o),
        .d_rdata_o (d_rdata_o),
        .m_req_o   (m_req_o),
        .m_we_o    (m_we_o),
        .m_be_o    (m_be_o),
        .m_addr_o  (m_addr_o),
        .m_wdata_o (m_wdata_o),
        .m_gnt_i   (m_gnt_i),
        .m_rvalid_i(m_rvalid_i),
        .m_rdata_i (m_rdata_i),
        .owner_o   (owner_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Downstream memory: 64-bit words, unwritten words hold an address pattern.
    logic [63:0] mem [logic [60:0]];

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a[63:3])) return mem[a[63:3]];
        return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
    endfunction

    task automatic mem_wr(input logic [63:0] a, input logic [7:0] be, input logic [63:0] d);
        logic [63:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 8; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[a[63:3]] = w;
    endtask

    // Transaction-level model: kind 0 = none, 1 = I burst, 2 = D read, 3 = D write.
    int          cyc = 0;
    logic        mdl_owner;
    int          kind, beats_left, busy_until, last_prog;
    logic        err_pend;
    // Downstream responder
    int          rsp_left, rsp_ready, rsp_lat, rsp_emitted, stall_after;
    logic [63:0] rsp_addr;
    bit          jitter, gnt_rand, stray;
    // Observations
    bit          acc_i, acc_d;
    int          i_rv_cnt, d_rv_cnt, err_cnt, err_cyc, last_beat_cyc, gnt_cyc;
    logic [63:0] last_d_rdata;
    int          gnt_side[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        kind = 0; mdl_owner = 1'b0; err_pend = 1'b0;
        rsp_left = 0; rsp_emitted = 0; stray = 0;
    endtask

    // One clock cycle: drive downstream at negedge, check, update model, pass posedge.
    task automatic step();
        logic emit, idle, any, sel_d, accept;
        logic err_nxt;
        @(negedge clk_i);
        m_gnt_i = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        emit = stray || (rsp_left > 0 && cyc >= rsp_ready &&
                         (stall_after < 0 || rsp_emitted < stall_after) &&
                         (!jitter || $urandom_range(0, 3) != 0));
        m_rvalid_i = emit;
        m_rdata_i  = stray ? 64'hBAD0_BAD0_BAD0_BAD0 :
                     (emit ? mem_rd(rsp_addr) : {$urandom, $urandom});
        #1;
        idle   = (kind == 0);
        any    = i_req_i || d_req_i;
        sel_d  = d_req_i && (!i_req_i || mdl_owner == 1'b0);
        accept = idle && any && m_gnt_i;
        chk("m_req", m_req_o, idle && any);
        chk("i_gnt", i_gnt_o, accept && !sel_d);
        chk("d_gnt", d_gnt_o, accept && sel_d);
        if (idle && any) begin
            chk("m_addr",  m_addr_o,  sel_d ? d_addr_i : i_addr_i);
            chk("m_we",    m_we_o,    sel_d && d_we_i);
            chk("m_be",    m_be_o,    sel_d ? d_be_i : 8'hFF);
            chk("m_wdata", m_wdata_o, sel_d ? d_wdata_i : 64'h0);
        end
        chk("i_rvalid", i_rvalid_o, kind == 1 && emit);
        chk("d_rvalid", d_rvalid_o, kind == 2 && emit);
        if (kind == 1 && emit) chk("i_rdata", i_rdata_o, mem_rd(rsp_addr));
        if (kind == 2 && emit) chk("d_rdata", d_rdata_o, mem_rd(rsp_addr));
        chk("busy",  busy_o,  !idle);
        chk("owner", owner_o, mdl_owner);
        chk("err",   err_o,   err_pend);
        if (i_rvalid_o === 1'b1) i_rv_cnt++;
        if (d_rvalid_o === 1'b1) begin d_rv_cnt++; last_d_rdata = d_rdata_o; end
        if (err_o === 1'b1) begin err_cnt++; err_cyc = cyc; end
        if (i_gnt_o === 1'b1) gnt_side.push_back(0);
        if (d_gnt_o === 1'b1) gnt_side.push_back(1);
        acc_i = accept && !sel_d;
        acc_d = accept && sel_d;
        err_nxt = 1'b0;
        if (idle) begin
            if (emit) err_nxt = 1'b1;
            if (accept) begin
                mdl_owner = sel_d;
                last_prog = cyc;
                gnt_cyc   = cyc;
                if (!sel_d) begin
                    kind = 1; beats_left = BURST_BEATS; rsp_left = BURST_BEATS;
                    rsp_addr = i_addr_i; rsp_ready = cyc + 1 + rsp_lat; rsp_emitted = 0;
                end else if (d_we_i) begin
                    kind = 3; busy_until = cyc + WR_GAP + 1;
                    mem_wr(d_addr_i, d_be_i, d_wdata_i);
                end else begin
                    kind = 2; beats_left = 1; rsp_left = 1;
                    rsp_addr = d_addr_i; rsp_ready = cyc + 1 + rsp_lat; rsp_emitted = 0;
                end
                if (gnt_rand) rsp_lat = $urandom_range(0, 3);
            end
        end else if (kind == 3) begin
            if (emit) err_nxt = 1'b1;
            if (cyc == busy_until) kind = 0;
        end else begin
            if (emit) begin
                beats_left--; rsp_left--; rsp_emitted++;
                rsp_addr = rsp_addr + 64'd8;
                last_prog = cyc; last_beat_cyc = cyc;
                if (beats_left == 0) kind = 0;
            end else if (cyc - last_prog == int'(TIMEOUT)) begin
                err_nxt = 1'b1; kind = 0; rsp_left = 0;
            end
        end
        err_pend = err_nxt;
        stray = 0;
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((kind != 0 || err_pend) && n < 300) begin step(); n++; end
        if (n >= 300) chk("drain_bound", busy_o, 1'b0);
        step();
    endtask

    task automatic req_i(input logic [63:0] a, output int wait_cyc);
        int n = 0;
        i_req_i = 1'b1; i_addr_i = a;
        step();
        while (!acc_i && n < 50) begin step(); n++; end
        if (!acc_i) chk("i_gnt_bound", i_gnt_o, 1'b1);
        i_req_i = 1'b0;
        wait_cyc = n;
    endtask

    task automatic req_d(input logic we, input logic [7:0] be, input logic [63:0] a,
                         input logic [63:0] wd);
        int n = 0;
        d_req_i = 1'b1; d_we_i = we; d_be_i = be; d_addr_i = a; d_wdata_i = wd;
        step();
        while (!acc_d && n < 50) begin step(); n++; end
        if (!acc_d) chk("d_gnt_bound", d_gnt_o, 1'b1);
        d_req_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_i_gnt"}, i_gnt_o, 0);       chk({tag, "_d_gnt"}, d_gnt_o, 0);
        chk({tag, "_i_rvalid"}, i_rvalid_o, 0); chk({tag, "_d_rvalid"}, d_rvalid_o, 0);
        chk({tag, "_i_rdata"}, i_rdata_o, 0);   chk({tag, "_d_rdata"}, d_rdata_o, 0);
        chk({tag, "_m_req"}, m_req_o, 0);       chk({tag, "_m_we"}, m_we_o, 0);
        chk({tag, "_m_be"}, m_be_o, 0);         chk({tag, "_m_addr"}, m_addr_o, 0);
        chk({tag, "_m_wdata"}, m_wdata_o, 0);   chk({tag, "_owner"}, owner_o, 0);
        chk({tag, "_busy"}, busy_o, 0);         chk({tag, "_err"}, err_o, 0);
    endtask

    initial begin
        int w, i0, d0, e0, g_wr;
        jitter = 0; gnt_rand = 0; rsp_lat = 1; stall_after = -1;
        i_rv_cnt = 0; d_rv_cnt = 0; err_cnt = 0; err_cyc = 0; last_beat_cyc = 0; gnt_cyc = 0;
        last_d_rdata = '0; acc_i = 0; acc_d = 0; busy_until = 0; last_prog = 0;
        beats_left = 0; rsp_ready = 0; rsp_addr = '0;
        model_reset();
        mem[61'(64'h10000 >> 3)] = 64'hDEADBEEF_DEADBEEF;
        mem[61'(64'h20000 >> 3)] = 64'h12345678_9ABCDEF0;

        // Reset with every input active: all outputs must read 0.
        rst_ni = 1'b0;
        i_req_i = 1'b1; i_addr_i = 64'h1111; d_req_i = 1'b1; d_we_i = 1'b1;
        d_be_i = 8'hFF; d_addr_i = 64'h2222; d_wdata_i = 64'h3333;
        m_gnt_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 64'h4444;
        #12;
        check_all_zero("reset");
        @(negedge clk_i);
        i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0; m_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Both requesting continuously: D first, then strict alternation.
        gnt_side.delete();
        i_req_i = 1'b1; i_addr_i = 64'h8000;
        d_req_i = 1'b1; d_we_i = 1'b0; d_be_i = 8'hFF; d_addr_i = 64'h9000;
        w = 0;
        while (gnt_side.size() < 10 && w < 400) begin step(); w++; end
        i_req_i = 1'b0; d_req_i = 1'b0;
        drain();
        chk("rr_grant_count", gnt_side.size(), 10);
        for (int k = 0; k < 10 && k < gnt_side.size(); k++)
            chk($sformatf("rr_side_%0d", k), gnt_side[k], (k % 2 == 0) ? 1 : 0);

        // I-side alone: zero-latency grant, 8 beats, no D response.
        i0 = i_rv_cnt; d0 = d_rv_cnt;
        req_i(64'h1000, w);
        chk("i_gnt_latency", w, 0);
        drain();
        chk("i_burst_beats", i_rv_cnt - i0, BURST_BEATS);
        chk("i_burst_no_d", d_rv_cnt - d0, 0);
        chk("i_burst_idle", busy_o, 1'b0);

        // D-side read of preloaded word.
        d0 = d_rv_cnt;
        req_d(1'b0, 8'hFF, 64'h10000, 64'h0);
        drain();
        chk("d_read_data", last_d_rdata, 64'hDEADBEEF_DEADBEEF);
        chk("d_read_owner", owner_o, 1'b1);
        chk("d_read_count", d_rv_cnt - d0, 1);

        // Posted write then read of the same word.
        req_d(1'b1, 8'h0F, 64'h20000, 64'h0000_0000_1122_3344);
        g_wr = gnt_cyc;
        req_d(1'b0, 8'hFF, 64'h20000, 64'h0);
        chk("wr_to_rd_gap", gnt_cyc - g_wr, WR_GAP + 2);
        drain();
        chk("wr_rd_data", last_d_rdata, 64'h12345678_11223344);

        // Stall after beat 3: timeout error, then a stray response.
        i0 = i_rv_cnt; d0 = d_rv_cnt; e0 = err_cnt;
        stall_after = 4;
        req_i(64'h5000, w);
        w = 0;
        while (err_cnt == e0 && w < 200) begin step(); w++; end
        chk("stall_err_seen", err_cnt - e0, 1);
        chk("stall_err_delay", err_cyc - last_beat_cyc, TIMEOUT + 1);
        chk("stall_idle", busy_o, 1'b0);
        chk("stall_beats", i_rv_cnt - i0, 4);
        stall_after = -1;
        step(); step();
        stray = 1;
        step(); step(); step();
        chk("stray_err", err_cnt - e0, 2);
        chk("stray_no_i", i_rv_cnt - i0, 4);
        chk("stray_no_d", d_rv_cnt - d0, 0);

        // Reset during beat 4 of a burst, then a complete burst.
        i0 = i_rv_cnt;
        req_i(64'h3000, w);
        w = 0;
        while (i_rv_cnt - i0 < 4 && w < 100) begin step(); w++; end
        chk("pre_reset_beats", i_rv_cnt - i0, 4);
        @(negedge clk_i);
        m_gnt_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 64'h5555_5555_5555_5555;
        rst_ni = 1'b0;
        #1;
        check_all_zero("midrst");
        @(posedge clk_i); #1;
        model_reset();
        @(negedge clk_i);
        m_rvalid_i = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        i0 = i_rv_cnt;
        req_i(64'h4000, w);
        drain();
        chk("post_reset_beats", i_rv_cnt - i0, BURST_BEATS);

        // Random traffic with random grants and response jitter.
        gnt_rand = 1; jitter = 1;
        for (int n = 0; n < 600; n++) begin
            if (!i_req_i && $urandom_range(0, 3) == 0) begin
                i_req_i = 1'b1; i_addr_i = 64'h30000 + 64'($urandom_range(0, 15)) * 64'd8;
            end
            if (!d_req_i && $urandom_range(0, 2) == 0) begin
                d_req_i = 1'b1; d_we_i = 1'($urandom_range(0, 1));
                d_be_i = 8'($urandom); d_wdata_i = {$urandom, $urandom};
                d_addr_i = 64'h30000 + 64'($urandom_range(0, 15)) * 64'd8;
            end
            step();
            if (acc_i) i_req_i = 1'b0;
            if (acc_d) d_req_i = 1'b0;
        end
        i_req_i = 1'b0; d_req_i = 1'b0;
        drain();
        chk("final_idle", busy_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
